// File: rtl/camera64x64_dummy.sv
// Synthetic camera: streams a per-frame test pattern MSB-first on SDO,
// advancing one bit per falling edge of the asynchronous reader clock SCLK.
module camera64x64_dummy #(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = 64
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     SCLK,
   output logic                     SDO,
   output logic [$clog2(WIDTH)-1:0] PIX_X,
   output logic [$clog2(WIDTH)-1:0] PIX_Y,
   output logic [2:0]               BIT_IDX,
   output logic [7:0]               FRAME,
   output logic                     FRAME_DONE
);

   localparam int AW = $clog2(WIDTH);
   localparam logic [AW-1:0] LAST = AW'(WIDTH - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   hist_r;
   logic                   fall_s;
   logic [AW-1:0]          x_nx_s;
   logic [AW-1:0]          y_nx_s;
   logic [2:0]             bit_nx_s;
   logic [7:0]             frame_nx_s;
   logic [7:0]             pix_nx_s;
   logic                   done_nx_s;

   function automatic logic [7:0] pixel_value(input logic [AW-1:0] x,
                                              input logic [AW-1:0] y,
                                              input logic [7:0]    f);
      logic [7:0] xs;
      logic [7:0] ys;
      xs = 8'(x);
      ys = 8'(y);
      pixel_value = (xs * 8'd4) + ys + f;
   endfunction

   // SCLK synchroniser chain followed by the edge-history flop
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_r <= '0;
         hist_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], SCLK};
         hist_r <= sync_r[SYNC_STAGES-1];
      end
   end

   // Only falling edges move the stream, keeping SDO stable for the reader's rise
   assign fall_s = ~sync_r[SYNC_STAGES-1] & hist_r;

   // Next-state scan position, frame counter and end-of-frame pulse
   always_comb begin
      x_nx_s     = PIX_X;
      y_nx_s     = PIX_Y;
      bit_nx_s   = BIT_IDX;
      frame_nx_s = FRAME;
      done_nx_s  = 1'b0;
      if (fall_s) begin
         if (BIT_IDX != 3'd0) begin
            bit_nx_s = BIT_IDX - 3'd1;
         end else begin
            bit_nx_s = 3'd7;
            if (PIX_X == LAST) begin
               x_nx_s = '0;
               if (PIX_Y == LAST) begin
                  y_nx_s     = '0;
                  frame_nx_s = FRAME + 8'd1;
                  done_nx_s  = 1'b1;
               end else begin
                  y_nx_s = PIX_Y + {{(AW-1){1'b0}}, 1'b1};
               end
            end else begin
               x_nx_s = PIX_X + {{(AW-1){1'b0}}, 1'b1};
            end
         end
      end else begin
         done_nx_s = 1'b0;
      end
      // SDO is taken from the next-state position so it is never one bit stale
      pix_nx_s = pixel_value(x_nx_s, y_nx_s, frame_nx_s);
   end

   // Registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         PIX_X      <= '0;
         PIX_Y      <= '0;
         BIT_IDX    <= 3'd7;
         FRAME      <= 8'd0;
         FRAME_DONE <= 1'b0;
         SDO        <= 1'b0;
      end else begin
         PIX_X      <= x_nx_s;
         PIX_Y      <= y_nx_s;
         BIT_IDX    <= bit_nx_s;
         FRAME      <= frame_nx_s;
         FRAME_DONE <= done_nx_s;
         SDO        <= pix_nx_s[bit_nx_s];
      end
   end

endmodule

// File: tb/tb_camera64x64_dummy.sv
// Bench for camera64x64_dummy: a full-size instance and a WIDTH=8 instance
// (short frames) share CLK/RST/SCLK and are checked against a bit-count model.
module tb_camera64x64_dummy;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       SCLK = 1'b0;

   logic       d_sdo, d_done;
   logic [5:0] d_x, d_y;
   logic [2:0] d_bit;
   logic [7:0] d_frame;

   logic       s_sdo, s_done;
   logic [2:0] s_x, s_y;
   logic [2:0] s_bit;
   logic [7:0] s_frame;

   camera64x64_dummy #(.SYNC_STAGES(2), .WIDTH(64)) dut_big (
      .CLK(CLK), .RST(RST), .SCLK(SCLK), .SDO(d_sdo), .PIX_X(d_x), .PIX_Y(d_y),
      .BIT_IDX(d_bit), .FRAME(d_frame), .FRAME_DONE(d_done));

   camera64x64_dummy #(.SYNC_STAGES(2), .WIDTH(8)) dut_small (
      .CLK(CLK), .RST(RST), .SCLK(SCLK), .SDO(s_sdo), .PIX_X(s_x), .PIX_Y(s_y),
      .BIT_IDX(s_bit), .FRAME(s_frame), .FRAME_DONE(s_done));

   always #2 CLK = ~CLK;

   int     checks = 0;
   int     passes = 0;
   longint n = 0;           // falling edges consumed since last reset
   int     d_cnt = 0, s_cnt = 0, d_exp = 0, s_exp = 0, wide = 0;
   logic   d_prev = 1'b0, s_prev = 1'b0;

   // count FRAME_DONE pulses and flag any lasting more than one CLK
   always @(posedge CLK) begin
      #1;
      if (d_done && d_prev) wide++;
      if (s_done && s_prev) wide++;
      if (d_done) d_cnt++;
      if (s_done) s_cnt++;
      d_prev = d_done;
      s_prev = s_done;
   end

   // reference: position after cnt falling edges for a w x w frame
   function automatic logic [23:0] expect_state(input longint cnt, input int w);
      longint pix, pidx;
      int x, y, b, f;
      logic [7:0] v;
      pix  = cnt / 8;
      b    = 7 - int'(cnt % 8);
      f    = int'((pix / (w * w)) % 256);
      pidx = pix % (w * w);
      x    = int'(pidx % w);
      y    = int'(pidx / w);
      v    = 8'((4 * x + y + f) % 256);
      return {6'(x), 6'(y), 3'(b), 8'(f), v[b]};
   endfunction

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s got=%h exp=%h (edges=%0d)", nm, got, exp, n);
   endtask

   task automatic check_all(input string nm);
      cmp({nm, "/w64"}, {8'd0, d_x, d_y, d_bit, d_frame, d_sdo}, {8'd0, expect_state(n, 64)});
      cmp({nm, "/w8"}, {8'd0, 3'd0, s_x, 3'd0, s_y, s_bit, s_frame, s_sdo},
          {8'd0, expect_state(n, 8)});
      cmp({nm, "/done64"}, d_cnt, d_exp);
      cmp({nm, "/done8"}, s_cnt, s_exp);
   endtask

   // one reader clock period; sb/ss are what the reader sees at the rise
   task automatic sclk_cycle(input int hi, input int lo, output logic sb, output logic ss);
      sb = d_sdo;
      ss = s_sdo;
      SCLK = 1'b1;
      repeat (hi) @(negedge CLK);
      SCLK = 1'b0;
      repeat (lo) @(negedge CLK);
      n++;
      if (n % (8 * 64 * 64) == 0) d_exp++;
      if (n % (8 * 8 * 8) == 0) s_exp++;
   endtask

   task automatic do_reset(input string nm);
      RST = 1'b1;
      @(negedge CLK);
      cmp({nm, "/rst64"}, {8'd0, d_x, d_y, d_bit, d_frame, d_sdo, d_done},
          {8'd0, 6'd0, 6'd0, 3'd7, 8'd0, 1'b0, 1'b0});
      cmp({nm, "/rst8"}, {8'd0, s_x, s_y, s_bit, s_frame, s_sdo, s_done},
          {8'd0, 3'd0, 3'd0, 3'd7, 8'd0, 1'b0, 1'b0});
      RST = 1'b0;
      n = 0;
   endtask

   typedef struct {
      logic smp;
      int   x;
      int   b;
   } vec_t;

   vec_t tbl[15];

   initial begin
      logic [14:0] pat;
      logic        sb, ss;
      logic [7:0]  byte_d, byte_s;
      int          len, hi, lo;

      pat = 15'b000000000000010;
      for (int i = 0; i < 15; i++) begin
         tbl[i].smp = pat[14 - i];
         tbl[i].x   = (i + 1) / 8;
         tbl[i].b   = 7 - ((i + 1) % 8);
      end

      repeat (3) @(negedge CLK);
      do_reset("init");

      // first 8 MHz-like burst of 15 periods
      for (int i = 0; i < 15; i++) begin
         sclk_cycle(15, 15, sb, ss);
         cmp($sformatf("burst1[%0d]", i), {24'd0, sb, ss, d_x, d_bit},
             {24'd0, tbl[i].smp, tbl[i].smp, 6'(tbl[i].x), 3'(tbl[i].b)});
      end
      cmp("burst1_sdo", {31'd0, d_sdo}, 32'd0);
      check_all("burst1");

      // long idle: nothing moves
      repeat (2000) @(negedge CLK);
      check_all("gap");

      // second burst continues mid-pixel
      sclk_cycle(15, 15, sb, ss);
      cmp("burst2_bit0", {31'd0, sb}, 32'd0);
      cmp("burst2_x2", {26'd0, d_x}, 32'd2);
      byte_d = 8'd0;
      for (int i = 0; i < 8; i++) begin
         sclk_cycle(15, 15, sb, ss);
         byte_d = {byte_d[6:0], sb};
      end
      cmp("burst2_byte", {24'd0, byte_d}, 32'h08);
      cmp("burst2_x3", {26'd0, d_x}, 32'd3);
      check_all("burst2");

      // row wrap on the big instance, frame wrap on the small one
      do_reset("row");
      for (int i = 0; i < 64 * 8; i++) sclk_cycle(4, 4, sb, ss);
      cmp("row_wrap", {16'd0, d_x, d_y, d_bit, d_sdo}, {16'd0, 6'd0, 6'd1, 3'd7, 1'b0});
      cmp("frame_wrap8", {18'd0, s_frame, s_x, s_y}, {18'd0, 8'd1, 3'd0, 3'd0});
      cmp("frame_done8", s_cnt, 1);
      check_all("wrap");
      byte_s = 8'd0;
      for (int i = 0; i < 8; i++) begin
         sclk_cycle(4, 4, sb, ss);
         byte_s = {byte_s[6:0], ss};
      end
      cmp("frame1_byte8", {24'd0, byte_s}, 32'h01);

      // reset between edges mid-pixel
      for (int i = 0; i < 3; i++) sclk_cycle(5, 5, sb, ss);
      do_reset("midpix");
      byte_d = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         sclk_cycle(6, 6, sb, ss);
         byte_d = {byte_d[6:0], sb};
      end
      cmp("midpix_byte", {24'd0, byte_d}, 32'h00);
      check_all("midpix");

      // randomized bursts, gaps and resets against the model
      for (int k = 0; k < 25; k++) begin
         if ($urandom_range(0, 7) == 0) do_reset("rand");
         len = $urandom_range(1, 150);
         for (int i = 0; i < len; i++) begin
            hi = $urandom_range(4, 7);
            lo = $urandom_range(4, 7);
            sclk_cycle(hi, lo, sb, ss);
            check_all("rand");
         end
         repeat ($urandom_range(1, 400)) @(negedge CLK);
         check_all("rand_gap");
      end

      cmp("pulse_width", wide, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
